ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 12, meaning the width of the decoded control word carried down the pipeline.
REQ-002 SHALL have parameter BEATS, default 4, meaning the number of execute beats per vector operation (1 to 64).
REQ-003 SHALL have derived localparam BEAT_W = max(1, clog2(BEATS)).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 ctrlD  in  CTRL_W  decoded control word in decode.
REQ-008 validD  in  1  ctrlD holds a real instruction.
REQ-009 vecD  in  1  instruction is a multi-beat vector op.
REQ-010 stallE, stallM  in  1  external hold requests for the execute and memory stages.
REQ-011 flushE  in  1  turns execute into a bubble.
REQ-012 ctrlE, ctrlM, ctrlW  out  CTRL_W  control word in E, M and W.
REQ-013 validE, validM, validW  out  1  stage holds a real instruction.
REQ-014 beatE, beatM, beatW  out  BEAT_W  beat index of the stage's instruction.
REQ-015 lastbeatE  out  1  E holds the final (or only) beat.
REQ-016 busyD  out  1  decode must hold because E is mid-vector.

Function
REQ-017 SHALL use effective E stall stE = stallE | stallM.
- A stall in M always freezes E.
REQ-018 SHALL run a two-state FSM: RUN and VEC.
- RUN to VEC: E loads validD=1, vecD=1 with BEATS>1.
- VEC to RUN: the last beat leaves E, a flush occurs, or reset occurs.
REQ-019 SHALL set lastbeatE = ~(validE & vecE) | (beatE == BEATS-1), combinationally.
REQ-020 SHALL set busyD = validE & vecE & ~lastbeatE, combinationally.
- Upstream freezes D while busyD=1.
- The block ignores ctrlD while busyD=1.
REQ-021 SHALL update the E register each cycle with priority reset > flushE > stE > busy > load:
- flushE: validE=0, ctrlE=0, beatE=0, state RUN.
- stE: hold all E state.
- busy: keep ctrlE, increment beatE by 1.
- load: ctrlE=validD?ctrlD:0, validE=validD, vecE=vecD&validD, beatE=0.
REQ-022 SHALL update the M register each cycle:
- If stallM: hold all M state.
- Else if stE or flushE is asserted this cycle: insert a bubble (validM=0, ctrlM=0, beatM=0).
- Else: load ctrlE/validE/beatE.
- Each vector beat reaches M exactly once.
REQ-023 SHALL update the W register each cycle:
- If stallM: bubble (validW=0, ctrlW=0, beatW=0).
- Else: load from M.
REQ-024 SHALL make scalar latency D to E, E to M, M to W one cycle each, i.e. 3 cycles from D to W.
REQ-025 SHALL make a vector op occupy E for exactly BEATS unstalled cycles.
- beatE wraps never: it returns to 0 only on load, flush or reset.
REQ-026 SHALL treat vecD as scalar when BEATS=1 (lastbeatE=1, busyD=0).
REQ-027 SHALL drive vecE and the FSM state as internal state only; they are not exported.
REQ-028 SHALL handle simultaneous events as follows:
- flushE with stallE: flush wins.
- flushE mid-vector: the remaining beats are aborted.
- Beats already in M/W complete unchanged.

Reset
REQ-029 SHALL, on reset, clear every output register to 0: ctrl*, valid*, beat*, and state=RUN.
- Consequently lastbeatE=1 and busyD=0.
REQ-030 SHALL let reset mid-vector abandon the op immediately, with no further beats emitted.

Verification (CTRL_W=12, BEATS=4)
REQ-031 Reset scenario:
- Stimulus: reset high 2 cycles with ctrlD=0xFFF, validD=1.
- Required: all outputs 0 except lastbeatE=1.
REQ-032 Scalar stream scenario:
- Stimulus: 0x0A5 valid scalar at cycle 0.
- Required: ctrlE=0x0A5 at cycle 1, ctrlM=0x0A5 at cycle 2, ctrlW=0x0A5 at cycle 3, each with valid=1 and beat=0.
REQ-033 Vector issue scenario:
- Stimulus: 0x3C1 with vecD=1, followed by scalar 0x011.
- Required: beatE=0,1,2,3 on cycles 1-4.
- Required: busyD=1 on cycles 1-3.
- Required: beatM=0..3 on cycles 2-5.
- Required: ctrlE=0x011 on cycle 5.
REQ-034 Stall mid-vector scenario:
- Stimulus: stallE=1 for 2 cycles while beatE=1.
- Required: beatE holds 1.
- Required: validM=0 for 2 cycles, then beatM=1.
- Required: no beat is duplicated or lost.
REQ-035 Flush mid-vector scenario:
- Stimulus: flushE at beatE=2.
- Required: next cycle validE=0, beatE=0, busyD=0.
- Required: beat 1 still retires in W.
REQ-036 Memory stall scenario:
- Stimulus: stallM=1 for 1 cycle with valid E and M.
- Required: E and M hold, validW=0 that cycle, then W resumes with the held M word.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Decode-to-writeback control bundle: D-side inputs, stage holds, and per-stage control/valid/beat outputs.
interface ctrl_pipe_if #(
    parameter int CTRL_W = 12,
    parameter int BEATS  = 4
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CTRL_W-1:0] ctrlD;
    logic              validD;
    logic              vecD;
    logic              stallE;
    logic              stallM;
    logic              flushE;

    logic [CTRL_W-1:0] ctrlE;
    logic [CTRL_W-1:0] ctrlM;
    logic [CTRL_W-1:0] ctrlW;
    logic              validE;
    logic              validM;
    logic              validW;
    logic [BEAT_W-1:0] beatE;
    logic [BEAT_W-1:0] beatM;
    logic [BEAT_W-1:0] beatW;
    logic              lastbeatE;
    logic              busyD;

    modport master (
        output ctrlD, validD, vecD, stallE, stallM, flushE,
        input  ctrlE, ctrlM, ctrlW, validE, validM, validW,
        input  beatE, beatM, beatW, lastbeatE, busyD
    );

    modport slave (
        input  ctrlD, validD, vecD, stallE, stallM, flushE,
        output ctrlE, ctrlM, ctrlW, validE, validM, validW,
        output beatE, beatM, beatW, lastbeatE, busyD
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline E -> M -> W with multi-beat vector sequencing in E.
// A vector op sits in E for BEATS unstalled cycles, emitting one beat to M per cycle.
module ctrl_pipe #(
    parameter int CTRL_W = 12,
    parameter int BEATS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_pipe_if.slave bus
);
    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic              MULTI     = 1'(BEATS > 1);

    typedef enum logic {RUN, VEC} state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic              valid_e_q, valid_e_d;
    logic              vec_e_q, vec_e_d;
    logic [BEAT_W-1:0] beat_e_q, beat_e_d;

    logic [CTRL_W-1:0] ctrl_m_q, ctrl_m_d;
    logic              valid_m_q, valid_m_d;
    logic [BEAT_W-1:0] beat_m_q, beat_m_d;

    logic [CTRL_W-1:0] ctrl_w_q, ctrl_w_d;
    logic              valid_w_q, valid_w_d;
    logic [BEAT_W-1:0] beat_w_q, beat_w_d;

    logic st_e;
    logic lastbeat_e;
    logic vec_busy;

    // A memory-stage hold must also freeze E, otherwise E would overrun M.
    assign st_e       = bus.stallE | bus.stallM;
    assign lastbeat_e = ~(valid_e_q & vec_e_q) | (beat_e_q == LAST_BEAT);
    assign vec_busy   = (state_q == VEC) & ~lastbeat_e;

    always_comb begin
        state_d   = state_q;
        ctrl_e_d  = ctrl_e_q;
        valid_e_d = valid_e_q;
        vec_e_d   = vec_e_q;
        beat_e_d  = beat_e_q;
        if (bus.flushE) begin
            state_d   = RUN;
            ctrl_e_d  = '0;
            valid_e_d = 1'b0;
            vec_e_d   = 1'b0;
            beat_e_d  = '0;
        end else if (st_e) begin
            state_d = state_q;
        end else if (vec_busy) begin
            beat_e_d = beat_e_q + BEAT_W'(1);
        end else begin
            ctrl_e_d  = bus.validD ? bus.ctrlD : '0;
            valid_e_d = bus.validD;
            vec_e_d   = bus.vecD & bus.validD & MULTI;
            beat_e_d  = '0;
            state_d   = (bus.validD & bus.vecD & MULTI) ? VEC : RUN;
        end
    end

    // M only accepts a beat on a cycle where E actually advances, so each beat lands once.
    always_comb begin
        ctrl_m_d  = ctrl_m_q;
        valid_m_d = valid_m_q;
        beat_m_d  = beat_m_q;
        if (bus.stallM) begin
            ctrl_m_d = ctrl_m_q;
        end else if (st_e | bus.flushE) begin
            ctrl_m_d  = '0;
            valid_m_d = 1'b0;
            beat_m_d  = '0;
        end else begin
            ctrl_m_d  = ctrl_e_q;
            valid_m_d = valid_e_q;
            beat_m_d  = beat_e_q;
        end
    end

    always_comb begin
        ctrl_w_d  = ctrl_m_q;
        valid_w_d = valid_m_q;
        beat_w_d  = beat_m_q;
        if (bus.stallM) begin
            ctrl_w_d  = '0;
            valid_w_d = 1'b0;
            beat_w_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            ctrl_e_q  <= '0;
            valid_e_q <= 1'b0;
            vec_e_q   <= 1'b0;
            beat_e_q  <= '0;
            ctrl_m_q  <= '0;
            valid_m_q <= 1'b0;
            beat_m_q  <= '0;
            ctrl_w_q  <= '0;
            valid_w_q <= 1'b0;
            beat_w_q  <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_e_q  <= ctrl_e_d;
            valid_e_q <= valid_e_d;
            vec_e_q   <= vec_e_d;
            beat_e_q  <= beat_e_d;
            ctrl_m_q  <= ctrl_m_d;
            valid_m_q <= valid_m_d;
            beat_m_q  <= beat_m_d;
            ctrl_w_q  <= ctrl_w_d;
            valid_w_q <= valid_w_d;
            beat_w_q  <= beat_w_d;
        end
    end

    assign bus.ctrlE     = ctrl_e_q;
    assign bus.validE    = valid_e_q;
    assign bus.beatE     = beat_e_q;
    assign bus.ctrlM     = ctrl_m_q;
    assign bus.validM    = valid_m_q;
    assign bus.beatM     = beat_m_q;
    assign bus.ctrlW     = ctrl_w_q;
    assign bus.validW    = valid_w_q;
    assign bus.beatW     = beat_w_q;
    assign bus.lastbeatE = lastbeat_e;
    assign bus.busyD     = valid_e_q & vec_e_q & ~lastbeat_e;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (CTRL_W=12, BEATS=4): reset, scalar, vector, stall, flush, memory stall, reset abort.
module tb_ctrl_pipe;
    localparam int CTRL_W = 12;
    localparam int BEATS  = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ctrl_pipe_if #(.CTRL_W(CTRL_W), .BEATS(BEATS)) bus ();

    ctrl_pipe #(.CTRL_W(CTRL_W), .BEATS(BEATS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] c, input logic v, input logic vec);
        bus.ctrlD  = c;
        bus.validD = v;
        bus.vecD   = vec;
    endtask

    task automatic chk_e(input string tag, input logic [11:0] c, input logic v, input logic [1:0] b);
        check({tag, ".ctrlE"},  32'(bus.ctrlE),  32'(c));
        check({tag, ".validE"}, 32'(bus.validE), 32'(v));
        check({tag, ".beatE"},  32'(bus.beatE),  32'(b));
    endtask

    task automatic chk_m(input string tag, input logic [11:0] c, input logic v, input logic [1:0] b);
        check({tag, ".ctrlM"},  32'(bus.ctrlM),  32'(c));
        check({tag, ".validM"}, 32'(bus.validM), 32'(v));
        check({tag, ".beatM"},  32'(bus.beatM),  32'(b));
    endtask

    task automatic chk_w(input string tag, input logic [11:0] c, input logic v, input logic [1:0] b);
        check({tag, ".ctrlW"},  32'(bus.ctrlW),  32'(c));
        check({tag, ".validW"}, 32'(bus.validW), 32'(v));
        check({tag, ".beatW"},  32'(bus.beatW),  32'(b));
    endtask

    initial begin
        logic [1:0] vec_be [1:5];
        logic       vec_busy [1:5];
        logic       vec_mv [1:5];
        logic [1:0] vec_bm [1:5];

        reset      = 1'b1;
        bus.stallE = 1'b0;
        bus.stallM = 1'b0;
        bus.flushE = 1'b0;
        drive(12'hFFF, 1'b1, 1'b0);

        // Reset: two cycles with a live instruction presented.
        tick();
        tick();
        chk_e("rst", 12'h000, 1'b0, 2'd0);
        chk_m("rst", 12'h000, 1'b0, 2'd0);
        chk_w("rst", 12'h000, 1'b0, 2'd0);
        check("rst.lastbeatE", 32'(bus.lastbeatE), 32'd1);
        check("rst.busyD",     32'(bus.busyD),     32'd0);

        // Scalar stream: one cycle per stage.
        reset = 1'b0;
        drive(12'h0A5, 1'b1, 1'b0);
        tick();
        chk_e("sc.c1", 12'h0A5, 1'b1, 2'd0);
        check("sc.c1.busyD", 32'(bus.busyD), 32'd0);
        drive(12'h000, 1'b0, 1'b0);
        tick();
        chk_m("sc.c2", 12'h0A5, 1'b1, 2'd0);
        tick();
        chk_w("sc.c3", 12'h0A5, 1'b1, 2'd0);
        tick();
        tick();

        // Vector issue followed by a scalar that waits behind busyD.
        vec_be   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        vec_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec_mv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vec_bm   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        drive(12'h3C1, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) drive(12'h011, 1'b1, 1'b0);
            check($sformatf("vec.c%0d.beatE", c), 32'(bus.beatE), 32'(vec_be[c]));
            check($sformatf("vec.c%0d.busyD", c), 32'(bus.busyD), 32'(vec_busy[c]));
            check($sformatf("vec.c%0d.validM", c), 32'(bus.validM), 32'(vec_mv[c]));
            if (vec_mv[c])
                check($sformatf("vec.c%0d.beatM", c), 32'(bus.beatM), 32'(vec_bm[c]));
            if (c <= 4)
                check($sformatf("vec.c%0d.ctrlE", c), 32'(bus.ctrlE), 32'h3C1);
        end
        check("vec.c5.ctrlE", 32'(bus.ctrlE), 32'h011);
        check("vec.c5.ctrlM", 32'(bus.ctrlM), 32'h3C1);
        drive(12'h000, 1'b0, 1'b0);
        tick();
        chk_w("vec.c6", 12'h3C1, 1'b1, 2'd3);
        tick();
        tick();
        tick();

        // Stall E for two cycles while beatE=1.
        drive(12'h2B7, 1'b1, 1'b1);
        tick();
        chk_e("stv.c1", 12'h2B7, 1'b1, 2'd0);
        drive(12'h000, 1'b0, 1'b0);
        tick();
        chk_e("stv.c2", 12'h2B7, 1'b1, 2'd1);
        chk_m("stv.c2", 12'h2B7, 1'b1, 2'd0);
        bus.stallE = 1'b1;
        tick();
        chk_e("stv.c3", 12'h2B7, 1'b1, 2'd1);
        chk_m("stv.c3", 12'h000, 1'b0, 2'd0);
        chk_w("stv.c3", 12'h2B7, 1'b1, 2'd0);
        tick();
        chk_e("stv.c4", 12'h2B7, 1'b1, 2'd1);
        chk_m("stv.c4", 12'h000, 1'b0, 2'd0);
        bus.stallE = 1'b0;
        tick();
        check("stv.c5.beatE", 32'(bus.beatE), 32'd2);
        chk_m("stv.c5", 12'h2B7, 1'b1, 2'd1);
        tick();
        check("stv.c6.beatE", 32'(bus.beatE), 32'd3);
        chk_m("stv.c6", 12'h2B7, 1'b1, 2'd2);
        tick();
        check("stv.c7.validE", 32'(bus.validE), 32'd0);
        chk_m("stv.c7", 12'h2B7, 1'b1, 2'd3);
        tick();
        chk_w("stv.c8", 12'h2B7, 1'b1, 2'd3);
        check("stv.c8.validM", 32'(bus.validM), 32'd0);
        tick();
        tick();

        // Flush (with a coincident stallE) at beatE=2.
        drive(12'h155, 1'b1, 1'b1);
        tick();
        drive(12'h000, 1'b0, 1'b0);
        tick();
        tick();
        chk_e("fl.c3", 12'h155, 1'b1, 2'd2);
        chk_m("fl.c3", 12'h155, 1'b1, 2'd1);
        bus.flushE = 1'b1;
        bus.stallE = 1'b1;
        tick();
        bus.flushE = 1'b0;
        bus.stallE = 1'b0;
        chk_e("fl.c4", 12'h000, 1'b0, 2'd0);
        check("fl.c4.busyD",     32'(bus.busyD),     32'd0);
        check("fl.c4.lastbeatE", 32'(bus.lastbeatE), 32'd1);
        check("fl.c4.validM",    32'(bus.validM),    32'd0);
        chk_w("fl.c4", 12'h155, 1'b1, 2'd1);
        tick();
        check("fl.c5.validW", 32'(bus.validW), 32'd0);
        check("fl.c5.validE", 32'(bus.validE), 32'd0);
        tick();

        // Memory stall for one cycle with valid E and M.
        drive(12'h101, 1'b1, 1'b0);
        tick();
        drive(12'h202, 1'b1, 1'b0);
        tick();
        chk_e("ms.c2", 12'h202, 1'b1, 2'd0);
        chk_m("ms.c2", 12'h101, 1'b1, 2'd0);
        drive(12'h000, 1'b0, 1'b0);
        bus.stallM = 1'b1;
        tick();
        bus.stallM = 1'b0;
        chk_e("ms.c3", 12'h202, 1'b1, 2'd0);
        chk_m("ms.c3", 12'h101, 1'b1, 2'd0);
        chk_w("ms.c3", 12'h000, 1'b0, 2'd0);
        tick();
        chk_w("ms.c4", 12'h101, 1'b1, 2'd0);
        chk_m("ms.c4", 12'h202, 1'b1, 2'd0);
        check("ms.c4.validE", 32'(bus.validE), 32'd0);
        tick();
        chk_w("ms.c5", 12'h202, 1'b1, 2'd0);
        tick();
        tick();

        // Reset mid-vector abandons the op.
        drive(12'h0F0, 1'b1, 1'b1);
        tick();
        drive(12'h000, 1'b0, 1'b0);
        tick();
        check("rv.c2.beatE", 32'(bus.beatE), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_e("rv.c3", 12'h000, 1'b0, 2'd0);
        chk_m("rv.c3", 12'h000, 1'b0, 2'd0);
        chk_w("rv.c3", 12'h000, 1'b0, 2'd0);
        check("rv.c3.busyD", 32'(bus.busyD), 32'd0);
        tick();
        check("rv.c4.validE", 32'(bus.validE), 32'd0);
        check("rv.c4.validM", 32'(bus.validM), 32'd0);
        tick();
        check("rv.c5.validW", 32'(bus.validW), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
